// File: rtl/parity_pkg.sv
// parity_pkg
//   Shared constants for the parity codec slice.
//   PARITY_EVEN / PARITY_ODD : values of odd_mode selecting the parity sense.
//   PARITY_BIT               : position of the parity bit in a coded word.
package parity_pkg;

    localparam logic        PARITY_EVEN = 1'b0;
    localparam logic        PARITY_ODD  = 1'b1;
    localparam int unsigned PARITY_BIT  = 0;

endpackage

// File: rtl/parity_slice.sv
// parity_slice
//   One-entry valid/ready register slice, WIDTH_S bits wide.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_data_i/in_valid_i    : upstream word and valid
//   in_ready_o              : slice can accept (empty, or draining this cycle)
//   out_data_o/out_valid_o  : registered word and valid
//   out_ready_i             : downstream accepts
module parity_slice #(
    parameter int unsigned WIDTH_S = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH_S-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [WIDTH_S-1:0] out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    logic [WIDTH_S-1:0] data_q;
    logic               valid_q;

    // Ready reads high throughout reset; anything offered then is dropped
    // because the reset branch below takes priority over the load.
    assign in_ready_o = rst_i | ~valid_q | out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            data_q  <= in_data_i;
            valid_q <= 1'b1;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/parity_codec.sv
// parity_codec
//   Parity generator (WIDTH -> WIDTH+1) and checker (WIDTH+1 -> WIDTH + err),
//   each behind a one-entry register slice, plus a saturating error counter.
//   clk, rst                        : clock, synchronous active-high reset
//   odd_mode                        : 0 even / 1 odd parity, sampled per accept
//   gen_in_*  / gen_out_*           : generate path in/out handshakes
//   chk_in_*  / chk_out_*           : check path in/out handshakes
//   err_clr                         : synchronous clear of err_count
//   err_count                       : saturating count of erroneous accepts
module parity_codec
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             odd_mode,
    input  logic [WIDTH-1:0] gen_in_data,
    input  logic             gen_in_valid,
    output logic             gen_in_ready,
    output logic [WIDTH:0]   gen_out_data,
    output logic             gen_out_valid,
    input  logic             gen_out_ready,
    input  logic [WIDTH:0]   chk_in_data,
    input  logic             chk_in_valid,
    output logic             chk_in_ready,
    output logic [WIDTH-1:0] chk_out_data,
    output logic             chk_out_err,
    output logic             chk_out_valid,
    input  logic             chk_out_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    logic             mode_odd;
    logic [WIDTH:0]   gen_word;
    logic             chk_err;
    logic [WIDTH:0]   chk_word;
    logic [WIDTH:0]   chk_word_q;
    logic             chk_acc;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    assign mode_odd = (odd_mode == PARITY_ODD);

    always_comb begin
        gen_word             = {gen_in_data, 1'b0};
        gen_word[PARITY_BIT] = ^gen_in_data ^ mode_odd;
    end

    // XOR spans payload and received parity bit: nonzero means a mismatch.
    assign chk_err  = ^chk_in_data ^ mode_odd;
    assign chk_word = {chk_in_data[WIDTH:1], chk_err};

    parity_slice #(.WIDTH_S(WIDTH + 1)) u_gen_slice (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (gen_word),
        .in_valid_i (gen_in_valid),
        .in_ready_o (gen_in_ready),
        .out_data_o (gen_out_data),
        .out_valid_o(gen_out_valid),
        .out_ready_i(gen_out_ready)
    );

    parity_slice #(.WIDTH_S(WIDTH + 1)) u_chk_slice (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (chk_word),
        .in_valid_i (chk_in_valid),
        .in_ready_o (chk_in_ready),
        .out_data_o (chk_word_q),
        .out_valid_o(chk_out_valid),
        .out_ready_i(chk_out_ready)
    );

    assign chk_out_data = chk_word_q[WIDTH:1];
    assign chk_out_err  = chk_word_q[0];

    assign chk_acc = chk_in_valid & chk_in_ready;

    // Clear is applied first so clear + erroneous accept yields 1.
    always_comb begin
        err_cnt_d = err_clr ? '0 : err_cnt_q;
        if (chk_acc && chk_err && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;

endmodule
